// File: rtl/seg_display_mux.sv
// seg_display_mux
//   Time-multiplexed N-digit seven-segment display controller. A free-running
//   slot counter steps through the digits; each digit slot is split into
//   2^BRIGHT_W brightness phases for PWM dimming. Display data is
//   double-buffered: `load` writes the shadow buffer, and the shadow buffer is
//   copied to the active buffer at each frame boundary. A load that lands on
//   the boundary cycle goes straight to both buffers. All pin outputs are
//   registered.
//
// Ports
//   clk          system clock
//   reset        asynchronous reset, active low
//   value        hex nibbles, nibble i = value[4i+3:4i], digit 0 rightmost
//   dp           per-digit decimal point request (1 = lit)
//   blank        per-digit force-off (1 = dark)
//   lz_suppress  enable leading-zero suppression (live)
//   load         capture value/dp/blank into the shadow buffer
//   brightness   PWM on-time control (live)
//   an           anodes, active low
//   sseg         segments {g,f,e,d,c,b,a}, active low
//   dp_out       decimal-point segment, active low
//   frame_done   one-cycle pulse with the first digit-0 output of a frame
module seg_display_mux #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BRIGHT_W    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  lz_suppress,
  input  logic                  load,
  input  logic [BRIGHT_W-1:0]   brightness,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            sseg,
  output logic                  dp_out,
  output logic                  frame_done
);

  localparam int unsigned PH_LEN = REFRESH_DIV >> BRIGHT_W;
  localparam int unsigned SUB_W  = (PH_LEN > 1) ? $clog2(PH_LEN) : 1;
  localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [SUB_W-1:0]    SUB_LAST = SUB_W'(PH_LEN - 1);
  localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [BRIGHT_W-1:0] PH_LAST  = '1;

  // Slot counter kept as {phase, sub}: cnt = phase*PH_LEN + sub. This yields
  // the PWM phase directly instead of dividing cnt by a non-power-of-two.
  logic [SUB_W-1:0]     r_sub;
  logic [BRIGHT_W-1:0]  r_phase;
  logic [IDX_W-1:0]     r_idx;

  logic [4*DIGITS-1:0]  r_val_s, r_val_a;
  logic [DIGITS-1:0]    r_dp_s, r_dp_a;
  logic [DIGITS-1:0]    r_blank_s, r_blank_a;

  logic [DIGITS-1:0]    r_an;
  logic [6:0]           r_sseg;
  logic                 r_dp_out;
  logic                 r_frame_done;
  logic                 r_boundary;

  logic                 w_sub_tc, w_slot_tc, w_wrap;
  logic                 w_run_zero;
  logic [DIGITS-1:0]    w_supp;
  logic [3:0]           w_nib;
  logic                 w_dp_cur, w_dark_cur;
  logic                 w_on, w_lit;
  logic [DIGITS-1:0]    w_an_nxt;

  function automatic logic [6:0] f_decode(input logic [3:0] nib);
    unique case (nib)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      4'hF: return 7'h0E;
    endcase
  endfunction

  assign w_sub_tc  = (r_sub == SUB_LAST);
  assign w_slot_tc = w_sub_tc && (r_phase == PH_LAST);
  assign w_wrap    = w_slot_tc && (r_idx == IDX_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sub   <= '0;
      r_phase <= '0;
      r_idx   <= '0;
    end else begin
      r_sub <= w_sub_tc ? '0 : r_sub + 1'b1;
      if (w_sub_tc) begin
        r_phase <= r_phase + 1'b1;
      end
      if (w_slot_tc) begin
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_val_s   <= '0;
      r_dp_s    <= '0;
      r_blank_s <= '0;
      r_val_a   <= '0;
      r_dp_a    <= '0;
      r_blank_a <= '0;
    end else begin
      if (load) begin
        r_val_s   <= value;
        r_dp_s    <= dp;
        r_blank_s <= blank;
      end
      // A load on the boundary cycle bypasses the shadow stage.
      if (w_wrap) begin
        r_val_a   <= load ? value : r_val_s;
        r_dp_a    <= load ? dp    : r_dp_s;
        r_blank_a <= load ? blank : r_blank_s;
      end
    end
  end

  // Suppression scans from the top digit down: digit i is suppressed while
  // every nibble from the top down to and including i is zero. Digit 0 never is.
  always_comb begin
    w_run_zero = 1'b1;
    w_supp     = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      w_run_zero = w_run_zero && (r_val_a[4*(DIGITS-1-k) +: 4] == 4'h0);
      w_supp[DIGITS-1-k] = lz_suppress && w_run_zero && (k != DIGITS-1);
    end
  end

  always_comb begin
    w_nib      = '0;
    w_dp_cur   = 1'b0;
    w_dark_cur = 1'b1;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_nib      = r_val_a[4*k +: 4];
        w_dp_cur   = r_dp_a[k];
        w_dark_cur = r_blank_a[k] | w_supp[k];
      end
    end
  end

  assign w_on  = (r_phase <= brightness);
  assign w_lit = w_on && !w_dark_cur;

  always_comb begin
    w_an_nxt = '1;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      w_an_nxt[k] = !(w_lit && (r_idx == IDX_W'(k)));
    end
  end

  // r_boundary marks that the counters just wrapped, so frame_done lines up
  // with the first registered output of digit 0 rather than the wrap cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_an         <= '1;
      r_sseg       <= '1;
      r_dp_out     <= 1'b1;
      r_boundary   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_an         <= w_an_nxt;
      r_sseg       <= w_lit ? f_decode(w_nib) : '1;
      r_dp_out     <= w_lit ? ~w_dp_cur : 1'b1;
      r_boundary   <= w_wrap;
      r_frame_done <= r_boundary;
    end
  end

  assign an         = r_an;
  assign sseg       = r_sseg;
  assign dp_out     = r_dp_out;
  assign frame_done = r_frame_done;

endmodule
